// File: rtl/prefetch_unit_pkg.sv
// Shared definitions for the instruction prefetch unit: fetch FSM states and fetch geometry.
package prefetch_unit_pkg;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StWait = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  localparam int unsigned WordBytes = 4;
  localparam int unsigned InstrW    = 32;

endpackage

// File: rtl/prefetch_unit_fetch_fifo.sv
// Instruction queue: power-of-two ring buffer with flush; head entry is read combinationally.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap for free because DEPTH is a power of two.
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: keeps one memory request in flight and fills a small queue for decode.
module prefetch_unit
  import prefetch_unit_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e             state_q;
  logic [ADDR_W-1:0]        pc_q, addr_q;
  logic                     req_q;
  logic [ADDR_W-1:0]        pc_next, redir_pc;
  logic [CntW-1:0]          count;
  logic                     full, empty, push, pop, room_after_push;
  logic [ADDR_W+InstrW-1:0] head;

  assign redir_pc = redirect_pc & ~ADDR_W'(WordBytes - 1);
  assign pc_next  = pc_q + ADDR_W'(WordBytes);

  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign push = (state_q == StWait) && imem_ack && !redirect_valid;
  // count+1-pop < DEPTH, rearranged to avoid underflow.
  assign room_after_push = pop || (count < CntW'(DEPTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRun;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
    end else begin
      unique case (state_q)
        StRun: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
          end else if (!full) begin
            state_q <= StWait;
            req_q   <= 1'b1;
            addr_q  <= pc_q;
          end
        end
        StWait: begin
          if (redirect_valid) begin
            pc_q <= redir_pc;
            if (imem_ack) begin
              state_q <= StRun;
              req_q   <= 1'b0;
            end else begin
              state_q <= StDrop;
            end
          end else if (imem_ack) begin
            pc_q <= pc_next;
            if (room_after_push) begin
              addr_q <= pc_next;
            end else begin
              state_q <= StRun;
              req_q   <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (redirect_valid) pc_q <= redir_pc;
          if (imem_ack) begin
            state_q <= StRun;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= StRun;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ADDR_W + InstrW)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata({pc_q, imem_rdata}),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instr_valid = !empty;
  assign instr_pc    = head[ADDR_W+InstrW-1:InstrW];
  assign instr_data  = head[InstrW-1:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Self-checking bench for prefetch_unit: directed scenarios plus random traffic against a queue model.
module tb_prefetch_unit;

  localparam int unsigned Depth   = 4;
  localparam logic [31:0] ResetPc = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  prefetch_unit #(
    .DEPTH   (Depth),
    .ADDR_W  (32),
    .RESET_PC(ResetPc)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_data    (instr_data),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } entry_t;

  // Reference model: a queue of fetched instructions plus the memory-side view.
  entry_t      q[$];
  bit          m_req;
  bit          m_discard;
  logic [31:0] m_addr;
  logic [31:0] m_pc;

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 1;
  int mem_wait = 0;
  int acks     = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_req     = 1'b0;
    m_discard = 1'b0;
    m_addr    = ResetPc;
    m_pc      = ResetPc;
    mem_wait  = 0;
  endtask

  task automatic check_outputs();
    check_eq("imem_req", 32'(imem_req), 32'(m_req));
    if (m_req) check_eq("imem_addr", imem_addr, m_addr);
    check_eq("instr_valid", 32'(instr_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check_eq("instr_pc", instr_pc, q[0].pc);
      check_eq("instr_data", instr_data, q[0].data);
    end
  endtask

  // Called just after a falling edge: check, drive, advance model, move to the next falling edge.
  task automatic step(input bit ready, input bit rv, input logic [31:0] rpc);
    bit          ack, req0, pop;
    logic [31:0] rd, tgt;
    int          sz0;
    check_outputs();
    req0 = m_req;
    ack  = m_req && (mem_wait + 1 >= lat);
    rd   = $urandom;
    imem_ack       = ack;
    imem_rdata     = rd;
    instr_ready    = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
    if (ack) acks++;

    tgt = {rpc[31:2], 2'b00};
    sz0 = q.size();
    pop = (sz0 != 0) && ready && !rv;
    if (rv) q.delete();
    else if (pop) void'(q.pop_front());
    if (!m_req) begin
      if (rv) m_pc = tgt;
      else if (sz0 < Depth) begin
        m_req  = 1'b1;
        m_addr = m_pc;
      end
    end else if (!m_discard) begin
      if (rv) begin
        m_pc = tgt;
        if (ack) m_req = 1'b0;
        else m_discard = 1'b1;
      end else if (ack) begin
        q.push_back('{pc: m_pc, data: rd});
        m_pc = m_pc + 32'd4;
        if (sz0 + 1 - int'(pop) < Depth) m_addr = m_pc;
        else m_req = 1'b0;
      end
    end else begin
      if (rv) m_pc = tgt;
      if (ack) begin
        m_req     = 1'b0;
        m_discard = 1'b0;
      end
    end

    if (req0 && ack) mem_wait = 0;
    else if (req0) mem_wait++;
    else mem_wait = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_addr", imem_addr, ResetPc);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !instr_valid; i++) step(1'b1, 1'b0, '0);
    check_eq("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  initial begin
    @(negedge clk);

    // Stream with 1-cycle memory: two-cycle fill, then one instruction per cycle.
    lat = 1;
    do_reset();
    step(1'b1, 1'b0, '0);
    check_eq("s1_fill", 32'(instr_valid), 32'd0);
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      check_eq("s1_pc", instr_pc, 32'(i * 4));
      step(1'b1, 1'b0, '0);
    end

    // Stalled decode fills the queue, then one pop lets exactly one request through.
    do_reset();
    acks = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0);
    check_eq("s2_pushes", 32'(acks), 32'd4);
    check_eq("s2_req_off", 32'(imem_req), 32'd0);
    acks = 0;
    step(1'b1, 1'b0, '0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0);
    check_eq("s2_one_req", 32'(acks), 32'd1);
    check_eq("s2_req_off2", 32'(imem_req), 32'd0);

    // Redirect while a slow request is outstanding.
    lat = 5;
    do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h100);
    wait_valid(40);
    check_eq("s3_pc", instr_pc, 32'h100);

    // Redirect coincident with ack and pop.
    lat = 1;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    step(1'b1, 1'b1, 32'h40);
    check_eq("s4_empty", 32'(instr_valid), 32'd0);
    check_eq("s4_run", 32'(imem_req), 32'd0);
    step(1'b1, 1'b0, '0);
    check_eq("s4_req", 32'(imem_req), 32'd1);
    check_eq("s4_addr", imem_addr, 32'h40);

    // Two redirects while dropping: the latest wins.
    lat = 6;
    do_reset();
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 32'h80);
    step(1'b1, 1'b1, 32'hC0);
    wait_valid(40);
    check_eq("s5_pc", instr_pc, 32'hC0);

    // Reset in the middle of a request with a stray ack during reset.
    lat = 3;
    do_reset();
    step(1'b1, 1'b0, '0);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    #2;
    check_eq("s6_req", 32'(imem_req), 32'd0);
    check_eq("s6_addr", imem_addr, ResetPc);
    check_eq("s6_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    do_reset();
    wait_valid(30);
    check_eq("s6_pc", instr_pc, ResetPc);

    // PC wraps modulo 2^32; low redirect bits are ignored.
    lat = 1;
    do_reset();
    step(1'b1, 1'b1, 32'hFFFF_FFFB);
    wait_valid(10);
    check_eq("wrap0", instr_pc, 32'hFFFF_FFF8);
    step(1'b1, 1'b0, '0);
    check_eq("wrap1", instr_pc, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, '0);
    check_eq("wrap2", instr_pc, 32'h0);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (mem_wait == 0 && $urandom_range(3) == 0) lat = $urandom_range(4, 1);
      if ($urandom_range(499) == 0) do_reset();
      else step($urandom_range(3) != 0, $urandom_range(19) == 0, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
